load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit of the RV32 core; sits directly upstream of the data memory on the shared data bus.
- Converts pipeline load/store requests (byte/half/word, signed/unsigned) into word-only bus transactions.
- Sub-word stores use read-modify-write, because the memory writes whole words only.
- Loads are extracted and extended, misalignment is flagged, and the pipeline is stalled while a transaction is in flight.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
RMW_ENABLE, 1, 1 = sub-word stores via read-modify-write; 0 = sub-word stores raise misaligned_err with no bus activity.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present; held stable by the requester while stall=1
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
req_unsigned  input  1  loads only: zero-extend instead of sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
stall  output  1  hold pipeline; a request is consumed in the cycle with req_valid=1 and stall=0
load_data  output  32  extended load result, valid when load_valid=1
load_valid  output  1  load result valid this cycle
misaligned_err  output  1  request rejected this cycle
data_bus_addr  output  32  word-aligned address, req_addr & ~3
data_bus_data  inout  32  driven only when data_bus_mode=10, else high-Z
data_bus_mode  output  2  00 idle, 01 read, 10 write
mem_read_strobe  output  1  memory latches its read word at this edge (memory stall_lw input)

Behaviour:
- Bus words use CPU-native little-endian lanes: byte k of a word is bits [8k+7:8k].
- States:
  - IDLE: accepts new requests.
  - LOAD_DATA: load data on bus.
  - RMW_DATA: old word on bus for merge.
  - RMW_WRITE: merged word written.
- Misalignment rules: a half with addr[0]=1 or a word with addr[1:0]!=0 is misaligned. misaligned_err=1 and stall=0 in that IDLE cycle, mode=00, no state change.
- Load (IDLE):
  - IDLE cycle: mode=01, mem_read_strobe=1, stall=1, next state LOAD_DATA.
  - LOAD_DATA: mode=01, strobe=0, stall=0, load_valid=1.
  - load_data is combinational from the bus word.
  - Lane select: byte lane = addr[1:0], half lane = addr[1].
  - Sign-extend unless req_unsigned. Next state IDLE.
  - Load latency = 2 cycles.
- Word store (IDLE): single cycle. mode=10, bus driven with req_wdata, stall=0, state stays IDLE.
- Sub-word store:
  - IDLE: read as for a load (strobe=1, stall=1), next state RMW_DATA.
  - RMW_DATA: mode=01, stall=1. Register merged = bus word with the selected lane(s) replaced by req_wdata[7:0] or [15:0]. Also register the aligned address. Next state RMW_WRITE.
  - RMW_WRITE: mode=10, drive the registered address and merged word, stall=0. Next state IDLE.
  - Total 3 cycles.
- req_valid=0 in IDLE: mode=00, bus high-Z, all flags 0.
- req_valid dropping in LOAD_DATA/RMW_DATA is a protocol violation; the FSM still completes the sequence.
- A request arriving while in RMW_WRITE is not consumed (the cycle belongs to the prior store). It is accepted in the following IDLE cycle.
- Reset:
  - Asynchronous; reset low forces state IDLE, merged register 0, address register 0.
  - While reset is low, all outputs are held inactive: stall=0, mode=00, strobe=0, flags 0, bus high-Z, load_data=0.
  - Reset mid-RMW abandons the write; memory is unchanged.
- No address range checking; out-of-range accesses float the bus, and loads return the resolved bus value.

Decomposition:
- Shared package `lsu_pkg`:
  - bus mode constants: BUS_IDLE=00, BUS_READ=01, BUS_WRITE=10
  - size constants: SIZE_B, SIZE_H, SIZE_W
  - FSM state encoding
- One combinational sub-module `lsu_lane_align`:
  - load extract/extend (word, size, offset, unsigned -> value)
  - store merge (old word, wdata, size, offset -> new word)
  - shared by the LOAD_DATA and RMW_DATA paths.

Test Plan:
- Preload word 0x8899AABB at 0x2004. LB 0x2005 signed -> stall 1 cycle, then load_valid=1, load_data=0xFFFFFFAA, bus addr 0x2004.
- LHU 0x2006 -> load_data=0x00008899. LH 0x2006 -> 0xFFFF8899. LW 0x2004 -> 0x8899AABB.
- SB 0x2007 data 0x11 -> cycles read, read, write; write word 0x1199AABB; stall pattern 1,1,0. Follow with LW 0x2004 -> 0x1199AABB.
- SW 0x2008 data 0xDEADBEEF -> single cycle, mode=10, stall=0. Bus high-Z on all non-write cycles, checked with a weak pull on the bench.
- LW 0x2002 and SH 0x2005 -> misaligned_err=1, mode=00, stall=0, memory unchanged.
- Reset during RMW_DATA of SH 0x2004 -> outputs inactive immediately, no write issued. After release, state IDLE and a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared bus mode, access size and FSM state encodings for the load/store unit
package lsu_pkg;
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [1:0] {IDLE, LOAD_DATA, RMW_DATA, RMW_WRITE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extract-and-extend for loads and lane merge for sub-word stores
module lsu_lane_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] mask;
  logic [4:0]      sh;
  // select the addressed lane, extend it, and build the lane-replaced store word
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    load_val = size == SIZE_B ? {{(XLEN-8){~is_unsigned & b[7]}}, b} :
               size == SIZE_H ? {{(XLEN-16){~is_unsigned & h[15]}}, h} : word;
    mask = size == SIZE_B ? XLEN'(8'hFF) : size == SIZE_H ? XLEN'(16'hFFFF) : '1;
    sh = size == SIZE_B ? {offset, 3'b000} : size == SIZE_H ? {offset[1], 4'b0000} : 5'd0;
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word pipeline requests into word-only bus reads, writes and read-modify-writes
module load_store_unit import lsu_pkg::*; #(
  parameter int XLEN       = 32,
  parameter bit RMW_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            misaligned_err,
  output logic [XLEN-1:0] data_bus_addr,
  inout  wire  [XLEN-1:0] data_bus_data,
  output logic [1:0]      data_bus_mode,
  output logic            mem_read_strobe
);
  lsu_state_t      state, state_n;
  logic [XLEN-1:0] merged_q, addr_q, aligned, load_val, merged, wdata_out;
  logic            is_word, mis;
  assign aligned = {req_addr[XLEN-1:2], 2'b00};
  assign is_word = req_size[1];
  assign mis = (req_size == SIZE_H && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00) ||
               (RMW_ENABLE == 1'b0 && req_write && !is_word);
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word(data_bus_data),
    .wdata(req_wdata),
    .size(req_size),
    .offset(req_addr[1:0]),
    .is_unsigned(req_unsigned),
    .load_val(load_val),
    .merged(merged)
  );
  assign data_bus_data = data_bus_mode == BUS_WRITE ? wdata_out : {XLEN{1'bz}};
  // state register plus the merged word and its address captured while the old word is on the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      merged_q <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_n;
      if (state == RMW_DATA) begin
        merged_q <= merged;
        addr_q   <= aligned;
      end
    end
  end
  // next state and bus/pipeline outputs; everything is forced inactive while reset is low
  always_comb begin
    state_n         = state;
    data_bus_mode   = BUS_IDLE;
    mem_read_strobe = 1'b0;
    stall           = 1'b0;
    load_valid      = 1'b0;
    misaligned_err  = 1'b0;
    data_bus_addr   = aligned;
    wdata_out       = req_wdata;
    case (state)
      IDLE: if (req_valid) begin
        if (mis) misaligned_err = 1'b1;
        else if (req_write && is_word) data_bus_mode = BUS_WRITE;
        else begin
          data_bus_mode   = BUS_READ;
          mem_read_strobe = 1'b1;
          stall           = 1'b1;
          state_n         = req_write ? RMW_DATA : LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        data_bus_mode = BUS_READ;
        load_valid    = 1'b1;
        state_n       = IDLE;
      end
      RMW_DATA: begin
        data_bus_mode = BUS_READ;
        stall         = 1'b1;
        state_n       = RMW_WRITE;
      end
      default: begin
        data_bus_mode = BUS_WRITE;
        data_bus_addr = addr_q;
        wdata_out     = merged_q;
        state_n       = IDLE;
      end
    endcase
    if (!reset) begin
      data_bus_mode   = BUS_IDLE;
      mem_read_strobe = 1'b0;
      stall           = 1'b0;
      load_valid      = 1'b0;
      misaligned_err  = 1'b0;
    end
    load_data = reset ? load_val : '0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven requests against a word memory model with a load/write scoreboard
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, load_valid, misaligned_err, mem_read_strobe;
  logic [31:0] load_data, data_bus_addr;
  logic [1:0]  data_bus_mode;
  tri1  [31:0] bus;
  logic [31:0] mem [0:15] = '{1: 32'h8899AABB, default: 32'h0};
  logic [31:0] rd_q = '0;
  int          checks = 0, fails = 0;
  logic [63:0] ld_q[$], wr_q[$];
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic        mis;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  load_store_unit #(.XLEN(32), .RMW_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .misaligned_err(misaligned_err),
    .data_bus_addr(data_bus_addr), .data_bus_data(bus),
    .data_bus_mode(data_bus_mode), .mem_read_strobe(mem_read_strobe)
  );

  always #5 clk = ~clk;

  // word memory: latches the read word on the strobe, writes on bus write cycles
  always @(posedge clk) begin
    if (data_bus_mode == 2'b10) mem[data_bus_addr[5:2]] <= bus;
    if (mem_read_strobe) rd_q <= mem[data_bus_addr[5:2]];
  end
  assign bus = data_bus_mode == 2'b01 ? rd_q : 32'hzzzz_zzzz;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sample();
    logic [63:0] e;
    if (load_valid) begin
      if (ld_q.size() == 0) check("unexpected_load", {data_bus_addr, load_data}, 64'hx);
      else begin
        e = ld_q.pop_front();
        check("load", {data_bus_addr, load_data}, e);
      end
    end
    if (data_bus_mode == 2'b10) begin
      if (wr_q.size() == 0) check("unexpected_write", {data_bus_addr, bus}, 64'hx);
      else begin
        e = wr_q.pop_front();
        check("write", {data_bus_addr, bus}, e);
      end
    end
    if (data_bus_mode == 2'b00) check("bus_hiz", {32'h0, bus}, {32'h0, 32'hFFFF_FFFF});
  endtask

  function automatic int exp_cycles(input vec_t v);
    return v.mis ? 1 : !v.w ? 2 : v.sz[1] ? 1 : 3;
  endfunction

  task automatic run_req(input vec_t v);
    int n;
    bit done;
    req_valid = 1'b1; req_write = v.w; req_size = v.sz; req_unsigned = v.u;
    req_addr = v.a; req_wdata = v.d;
    if (!v.mis && !v.w) ld_q.push_back({v.a & ~32'h3, v.exp});
    if (!v.mis && v.w) wr_q.push_back({v.a & ~32'h3, v.exp});
    n = 0;
    done = 1'b0;
    while (!done && n < 8) begin
      @(negedge clk);
      sample();
      if (n == 0) check("misaligned_err", {63'b0, misaligned_err}, {63'b0, v.mis});
      if (n == 0 && v.mis) check("mis_mode", {62'b0, data_bus_mode}, 64'h0);
      n++;
      done = !stall;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("cycles", 64'(n), 64'(exp_cycles(v)));
  endtask

  task automatic check_inactive(input string nm);
    check({nm, "_stall"}, {63'b0, stall}, 64'h0);
    check({nm, "_mode"}, {62'b0, data_bus_mode}, 64'h0);
    check({nm, "_strobe"}, {63'b0, mem_read_strobe}, 64'h0);
    check({nm, "_flags"}, {62'b0, load_valid, misaligned_err}, 64'h0);
    check({nm, "_load_data"}, {32'h0, load_data}, 64'h0);
    check({nm, "_bus"}, {32'h0, bus}, {32'h0, 32'hFFFF_FFFF});
  endtask

  initial begin
    //          w  sz     u  addr          wdata         mis exp
    vecs[0]  = '{0, 2'b00, 0, 32'h2005, 32'h0,        0, 32'hFFFF_FFAA};
    vecs[1]  = '{0, 2'b01, 1, 32'h2006, 32'h0,        0, 32'h0000_8899};
    vecs[2]  = '{0, 2'b01, 0, 32'h2006, 32'h0,        0, 32'hFFFF_8899};
    vecs[3]  = '{0, 2'b10, 0, 32'h2004, 32'h0,        0, 32'h8899_AABB};
    vecs[4]  = '{1, 2'b00, 0, 32'h2007, 32'h11,       0, 32'h1199_AABB};
    vecs[5]  = '{0, 2'b10, 0, 32'h2004, 32'h0,        0, 32'h1199_AABB};
    vecs[6]  = '{1, 2'b10, 0, 32'h2008, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vecs[7]  = '{0, 2'b11, 0, 32'h2008, 32'h0,        0, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 2'b10, 0, 32'h2002, 32'h0,        1, 32'h0};
    vecs[9]  = '{1, 2'b01, 0, 32'h2005, 32'hFFFF,     1, 32'h0};
    vecs[10] = '{0, 2'b10, 0, 32'h2004, 32'h0,        0, 32'h1199_AABB};
    vecs[11] = '{0, 2'b00, 1, 32'h2004, 32'h0,        0, 32'h0000_00BB};
    vecs[12] = '{1, 2'b01, 0, 32'h2006, 32'h1234_5678, 0, 32'h5678_AABB};
    vecs[13] = '{0, 2'b00, 0, 32'h2007, 32'h0,        0, 32'h0000_0056};
    vecs[14] = '{1, 2'b00, 0, 32'h2004, 32'hFF,       0, 32'h5678_AAFF};
    vecs[15] = '{0, 2'b01, 0, 32'h2004, 32'h0,        0, 32'hFFFF_AAFF};
    req_valid = 1'b1; req_addr = 32'h2004; req_size = 2'b10;
    repeat (2) begin
      @(negedge clk);
      check_inactive("reset");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    sample();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i]);
      @(negedge clk);
      sample();
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h2004; req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    sample();
    @(posedge clk); #1;
    @(negedge clk);
    check("rmw_data_stall", {63'b0, stall}, 64'h1);
    check("rmw_data_mode", {62'b0, data_bus_mode}, 64'h1);
    reset = 1'b0;
    #1;
    check_inactive("mid_rmw_reset");
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    sample();
    reset = 1'b1;
    @(posedge clk); #1;
    run_req('{0, 2'b10, 0, 32'h2004, 32'h0, 0, 32'h5678_AAFF});
    @(negedge clk);
    sample();
    check("load_queue_empty", 64'(ld_q.size()), 64'h0);
    check("write_queue_empty", 64'(wr_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
